// File: rtl/data_stack_pkg.sv
// rtl/data_stack_pkg.sv - op encoding and control state for the data stack
package data_stack_pkg;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_REPL = 2'b11;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } state_t;

endpackage

// File: rtl/data_stack_if.sv
// rtl/data_stack_if.sv - command and status bundle of the data stack
interface data_stack_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int CW    = $clog2(DEPTH + 3)
);
   logic [1:0]       op;
   logic             op_valid;
   logic             op_ready;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] tos;
   logic [WIDTH-1:0] nos;
   logic [CW-1:0]    count;
   logic             empty;
   logic             full;
   logic             err_under;
   logic             err_over;
   logic             err_clr;

   modport master (
      output op, op_valid, din, err_clr,
      input  op_ready, tos, nos, count, empty, full, err_under, err_over
   );

   modport slave (
      input  op, op_valid, din, err_clr,
      output op_ready, tos, nos, count, empty, full, err_under, err_over
   );
endinterface

// File: rtl/stack_ram.sv
// rtl/stack_ram.sv - single-port spill RAM, registered read, block-RAM friendly
module stack_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);
   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end
endmodule

// File: rtl/data_stack.sv
// rtl/data_stack.sv - LIFO with top two entries in registers, remainder spilled to RAM
module data_stack
   import data_stack_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   parameter int CW    = $clog2(DEPTH + 3)
) (
   input  logic         clk,
   input  logic         rst,
   data_stack_if.slave  bus
);
   localparam int            AW  = $clog2(DEPTH);
   localparam logic [CW-1:0] CAP = CW'(DEPTH + 2);

   state_t           state, state_nx;
   logic [WIDTH-1:0] tos_q, tos_nx, nos_q, nos_nx;
   logic [CW-1:0]    cnt_q, cnt_nx;
   logic             eu_q, eu_nx, eo_q, eo_nx;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [WIDTH-1:0] ram_rdata;
   logic             accept;

   assign accept = bus.op_valid && (state == ST_IDLE);

   stack_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (nos_q),
      .rdata (ram_rdata)
   );

   always_comb begin
      state_nx     = state;
      tos_nx       = tos_q;
      nos_nx       = nos_q;
      cnt_nx       = cnt_q;
      eu_nx        = eu_q & ~bus.err_clr;
      eo_nx        = eo_q & ~bus.err_clr;
      ram_we       = 1'b0;
      // Default address is the refill slot (sp-1); PUSH overrides it with sp.
      ram_addr     = AW'(cnt_q - CW'(3));
      bus.op_ready = (state == ST_IDLE);

      if (state == ST_REFILL) begin
         nos_nx   = ram_rdata;
         state_nx = ST_IDLE;
      end else if (accept) begin
         case (bus.op)
            OP_PUSH: begin
               if (cnt_q == CAP) begin
                  eo_nx = 1'b1;
               end else begin
                  tos_nx = bus.din;
                  nos_nx = tos_q;
                  cnt_nx = cnt_q + CW'(1);
                  if (cnt_q >= CW'(2)) begin
                     ram_we   = 1'b1;
                     ram_addr = AW'(cnt_q - CW'(2));
                  end
               end
            end
            OP_POP, OP_REPL: begin
               if ((bus.op == OP_POP  && cnt_q == CW'(0)) ||
                   (bus.op == OP_REPL && cnt_q <  CW'(2))) begin
                  eu_nx = 1'b1;
               end else begin
                  tos_nx = (bus.op == OP_POP) ? nos_q : bus.din;
                  cnt_nx = cnt_q - CW'(1);
                  if (cnt_q >= CW'(3)) begin
                     state_nx = ST_REFILL;
                  end else begin
                     nos_nx = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         tos_q <= '0;
         nos_q <= '0;
         cnt_q <= '0;
         eu_q  <= 1'b0;
         eo_q  <= 1'b0;
      end else begin
         state <= state_nx;
         tos_q <= tos_nx;
         nos_q <= nos_nx;
         cnt_q <= cnt_nx;
         eu_q  <= eu_nx;
         eo_q  <= eo_nx;
      end
   end

   assign bus.tos       = tos_q;
   assign bus.nos       = nos_q;
   assign bus.count     = cnt_q;
   assign bus.empty     = (cnt_q == CW'(0));
   assign bus.full      = (cnt_q == CAP);
   assign bus.err_under = eu_q;
   assign bus.err_over  = eo_q;
endmodule

// File: tb/tb_data_stack.sv
// tb/tb_data_stack.sv - randomized and directed checks of data_stack against a queue model
module tb_data_stack;
   import data_stack_pkg::*;

   localparam int W   = 32;
   localparam int D   = 4;
   localparam int CW  = $clog2(D + 3);
   localparam int CAP = D + 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   data_stack_if #(.WIDTH(W), .DEPTH(D), .CW(CW)) bus ();

   data_stack #(.WIDTH(W), .DEPTH(D), .CW(CW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int          passed = 0;
   int          total  = 0;
   logic [W-1:0] mq[$];
   logic        m_eu = 1'b0;
   logic        m_eo = 1'b0;
   logic        exp_refill;

   function automatic logic [W-1:0] exp_tos();
      return (mq.size() >= 1) ? mq[mq.size()-1] : '0;
   endfunction

   function automatic logic [W-1:0] exp_nos();
      return (mq.size() >= 2) ? mq[mq.size()-2] : '0;
   endfunction

   function automatic logic [2*W+CW+3:0] exp_vec();
      return {exp_tos(), exp_nos(), CW'(mq.size()), mq.size() == 0, mq.size() == CAP, m_eu, m_eo};
   endfunction

   function automatic logic [2*W+CW+3:0] dut_vec();
      return {bus.tos, bus.nos, bus.count, bus.empty, bus.full, bus.err_under, bus.err_over};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete();
      m_eu = 1'b0;
      m_eo = 1'b0;
   endtask

   // Drives one cycle of command and advances the model; callers do the checking.
   task automatic step(input logic v, input logic [1:0] o, input logic [W-1:0] d, input logic clr);
      int n = mq.size();
      logic nu = 1'b0;
      logic no = 1'b0;
      exp_refill  = 1'b0;
      bus.op_valid = v;
      bus.op       = o;
      bus.din      = d;
      bus.err_clr  = clr;
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
      bus.err_clr  = 1'b0;
      if (v) begin
         case (o)
            OP_PUSH: if (n < CAP) mq.push_back(d); else no = 1'b1;
            OP_POP:  if (n >= 1) begin void'(mq.pop_back()); exp_refill = (n >= 3); end else nu = 1'b1;
            OP_REPL: if (n >= 2) begin
                        void'(mq.pop_back()); void'(mq.pop_back()); mq.push_back(d);
                        exp_refill = (n >= 3);
                     end else nu = 1'b1;
            default: ;
         endcase
      end
      m_eu = nu | (m_eu & ~clr);
      m_eo = no | (m_eo & ~clr);
   endtask

   task automatic test_reset();
      bus.op_valid = 1'b1; bus.op = OP_PUSH; bus.din = 32'hDEAD; bus.err_clr = 1'b0;
      rst = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0; bus.op_valid = 1'b0;
      mq.delete(); m_eu = 1'b0; m_eo = 1'b0;
      total++;
      if ({bus.count, bus.tos, bus.nos, bus.empty, bus.full, bus.op_ready, bus.err_under, bus.err_over}
          !== {CW'(0), 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0})
         $display("FAIL reset: count=%0d tos=%h nos=%h empty=%b full=%b ready=%b eu=%b eo=%b",
                  bus.count, bus.tos, bus.nos, bus.empty, bus.full, bus.op_ready, bus.err_under, bus.err_over);
      else passed++;
   endtask

   task automatic test_push_pop();
      logic [W-1:0] et[3] = '{32'h33, 32'h22, 32'h11};
      logic [W-1:0] en[3] = '{32'h22, 32'h11, 32'h0};
      logic         er[3] = '{1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, OP_PUSH, W'(32'h11 * (i + 1)), 1'b0);
         total++;
         if (bus.op_ready !== 1'b1) $display("FAIL push_ready[%0d]: got %b want 1", i, bus.op_ready);
         else passed++;
      end
      total++;
      if ({bus.count, bus.tos, bus.nos} !== {CW'(4), 32'h44, 32'h33})
         $display("FAIL push4: count=%0d tos=%h nos=%h want 4/44/33", bus.count, bus.tos, bus.nos);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, OP_POP, 32'hBAD0, 1'b0);
         total++;
         if (bus.op_ready !== er[i]) $display("FAIL pop_ready[%0d]: got %b want %b", i, bus.op_ready, er[i]);
         else passed++;
         if (!er[i]) begin @(posedge clk); #1; end
         total++;
         if ({bus.tos, bus.nos, bus.op_ready} !== {et[i], en[i], 1'b1})
            $display("FAIL pop[%0d]: tos=%h nos=%h ready=%b want %h/%h/1", i, bus.tos, bus.nos, bus.op_ready, et[i], en[i]);
         else passed++;
      end
      total++;
      if (bus.count !== CW'(1)) $display("FAIL pop_count: got %0d want 1", bus.count);
      else passed++;
   endtask

   task automatic test_underflow();
      do_reset();
      step(1'b1, OP_POP, 32'h0, 1'b0);
      total++;
      if ({bus.err_under, bus.count, bus.op_ready} !== {1'b1, CW'(0), 1'b1})
         $display("FAIL underflow: eu=%b count=%0d ready=%b want 1/0/1", bus.err_under, bus.count, bus.op_ready);
      else passed++;
      step(1'b0, OP_NOP, 32'h0, 1'b1);
      total++;
      if (bus.err_under !== 1'b0) $display("FAIL err_clr: eu=%b want 0", bus.err_under);
      else passed++;
      step(1'b1, OP_POP, 32'h0, 1'b1);
      total++;
      if (bus.err_under !== 1'b1) $display("FAIL err_clr_vs_new: eu=%b want 1", bus.err_under);
      else passed++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < CAP; i++) step(1'b1, OP_PUSH, W'(32'hA1 + i), 1'b0);
      total++;
      if ({bus.count, bus.full, bus.empty} !== {CW'(6), 1'b1, 1'b0})
         $display("FAIL fill: count=%0d full=%b empty=%b want 6/1/0", bus.count, bus.full, bus.empty);
      else passed++;
      step(1'b1, OP_PUSH, 32'hFF, 1'b0);
      total++;
      if ({bus.err_over, bus.tos, bus.count} !== {1'b1, 32'hA6, CW'(6)})
         $display("FAIL overflow: eo=%b tos=%h count=%0d want 1/a6/6", bus.err_over, bus.tos, bus.count);
      else passed++;
      for (int i = 0; i < CAP; i++) begin
         total++;
         if (bus.tos !== W'(32'hA6 - i)) $display("FAIL lifo[%0d]: tos=%h want %h", i, bus.tos, 32'hA6 - i);
         else passed++;
         step(1'b1, OP_POP, 32'h0, 1'b0);
         if (exp_refill) begin @(posedge clk); #1; end
      end
      total++;
      if ({bus.empty, bus.count, bus.err_over} !== {1'b1, CW'(0), 1'b1})
         $display("FAIL drain: empty=%b count=%0d eo=%b want 1/0/1", bus.empty, bus.count, bus.err_over);
      else passed++;
   endtask

   task automatic test_repl();
      do_reset();
      for (int i = 1; i <= 3; i++) step(1'b1, OP_PUSH, W'(i), 1'b0);
      step(1'b1, OP_REPL, 32'h9, 1'b0);
      total++;
      if (bus.op_ready !== 1'b0) $display("FAIL repl_ready: got %b want 0", bus.op_ready);
      else passed++;
      @(posedge clk); #1;
      total++;
      if ({bus.tos, bus.nos, bus.count} !== {32'h9, 32'h1, CW'(2)})
         $display("FAIL repl: tos=%h nos=%h count=%0d want 9/1/2", bus.tos, bus.nos, bus.count);
      else passed++;
      step(1'b1, OP_POP, 32'h0, 1'b0);
      step(1'b1, OP_REPL, 32'h77, 1'b0);
      total++;
      if ({bus.err_under, bus.tos, bus.count} !== {1'b1, 32'h1, CW'(1)})
         $display("FAIL repl_under: eu=%b tos=%h count=%0d want 1/1/1", bus.err_under, bus.tos, bus.count);
      else passed++;
   endtask

   task automatic test_reset_in_refill();
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, OP_PUSH, W'(32'h60 + i), 1'b0);
      step(1'b1, OP_POP, 32'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      mq.delete(); m_eu = 1'b0; m_eo = 1'b0;
      total++;
      if ({bus.count, bus.tos, bus.nos, bus.op_ready} !== {CW'(0), 32'h0, 32'h0, 1'b1})
         $display("FAIL rst_refill: count=%0d tos=%h nos=%h ready=%b", bus.count, bus.tos, bus.nos, bus.op_ready);
      else passed++;
      step(1'b1, OP_PUSH, 32'h5, 1'b0);
      total++;
      if ({bus.tos, bus.count} !== {32'h5, CW'(1)})
         $display("FAIL rst_push: tos=%h count=%0d want 5/1", bus.tos, bus.count);
      else passed++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(9) != 0, 2'($urandom_range(3)), $urandom, $urandom_range(11) == 0);
         total++;
         if (bus.op_ready !== !exp_refill) $display("FAIL rnd_ready[%0d]: got %b want %b", i, bus.op_ready, !exp_refill);
         else passed++;
         if (exp_refill) begin @(posedge clk); #1; end
         total++;
         if (dut_vec() !== exp_vec())
            $display("FAIL rnd_state[%0d]: got %h want %h", i, dut_vec(), exp_vec());
         else passed++;
      end
   endtask

   initial begin
      bus.op = OP_NOP; bus.op_valid = 1'b0; bus.din = '0; bus.err_clr = 1'b0;
      test_reset();
      test_push_pop();
      test_underflow();
      test_overflow();
      test_repl();
      test_reset_in_refill();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
